mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- N-master front end for the memory bus, the successor to single-core direct wiring of the multicycle top.
- Accepts independent request/ack transactions from NUM_MASTERS requesters (core fetch/data ports, debug/DMA), grants one at a time, drives the shared memory_bus strobes, and returns read data with a one-cycle ack.
- Parametrised in data width, master count and memory read latency.

Parameters:
- WIDTH, 32, data/address width; byte lanes BYTES = WIDTH/8.
- NUM_MASTERS, 2, number of requesting channels (>=2).
- READ_LATENCY, 1, cycles from strobe to valid bus_rdata (>=1).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- m_req  in  NUM_MASTERS  per-master request, held until ack.
- m_we  in  NUM_MASTERS  1 = write, 0 = read.
- m_addr  in  NUM_MASTERS*WIDTH  flattened; master i at [i*WIDTH +: WIDTH].
- m_wdata  in  NUM_MASTERS*WIDTH  flattened write data.
- m_byteen  in  NUM_MASTERS*BYTES  flattened byte enables.
- m_ack  out  NUM_MASTERS  one-hot one-cycle completion pulse.
- m_rdata  out  WIDTH  read data, broadcast; valid only with m_ack.
- bus_mem_read  out  1  memory read strobe.
- bus_mem_write  out  1  memory write strobe.
- bus_addr  out  WIDTH  memory address.
- bus_wdata  out  WIDTH  memory write data.
- bus_byteen  out  BYTES  memory byte enables.
- bus_rdata  in  WIDTH  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE, all outputs 0, rr pointer set so master 0 has highest priority; reset in any state aborts the transaction immediately, no ack issued.
- States: IDLE, ACCESS, RESP.
- IDLE: if any m_req, pick winner g (round-robin, starting at last_grant+1 modulo NUM_MASTERS); latch g, we, addr, wdata, byteen into registers; update last_grant = g; load counter = READ_LATENCY-1; go to ACCESS. No request: stay IDLE.
- ACCESS: bus_addr/bus_wdata/bus_byteen driven from latched regs for every ACCESS cycle. bus_mem_read (we=0) or bus_mem_write (we=1) is asserted only in the first ACCESS cycle. When counter==0, capture bus_rdata (reads only) and go to RESP; otherwise decrement.
- RESP: m_ack[g]=1 for exactly this cycle, m_rdata = captured data (0 for writes); bus strobes 0; next state IDLE.
- Latency: request seen in IDLE cycle 0 -> ack in cycle READ_LATENCY+1; next grant possible in cycle READ_LATENCY+2.
- Requests arriving or dropping while not IDLE are ignored; latched fields are immune to input changes after the grant.
- A master holding m_req through its RESP cycle is treated as a new request in the following IDLE.
- Dropping m_req before ack is illegal; the transaction still completes and acks.
- Round-robin wrap: after granting NUM_MASTERS-1, master 0 is searched first.
- m_ack and the bus strobes are never asserted in the same cycle.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; last_grant is unused and the rr pointer is not built.
- Undefined (default): round-robin as above.
- Ports and timing are identical in both builds.

Decomposition:
- Package mem_bus_pkg:
  - arb_state_t enum (IDLE, ACCESS, RESP).
  - localparam function for BYTES.
  - clog2-based index width for grant/last_grant.
- Sub-module rr_arbiter: combinational winner select from req vector and last_grant, returning a one-hot grant and an index. Compiles to a plain priority encoder under ARB_FIXED_PRIORITY_EN.

Test Plan:
- Single read, READ_LATENCY=1: m_req[0], addr 0x100, memory returns 0xDEADBEEF -> bus_mem_read high in cycle 1 only, m_ack[0] and m_rdata=0xDEADBEEF in cycle 2.
- Write: master 1 writes 0xCAFEF00D to 0x40 with byteen 0b0011 -> one bus_mem_write cycle with those exact fields; a later read of 0x40 returns 0x0000F00D.
- Contention, round-robin: both masters hold m_req continuously for 4 transactions -> grants 0,1,0,1. With ARB_FIXED_PRIORITY_EN -> grants 0,0,0,0.
- READ_LATENCY=3: single read -> address held 3 ACCESS cycles, strobe in the first only, ack at cycle 4, busy high in cycles 1-4.
- Reset mid-ACCESS: assert reset during the second ACCESS cycle -> next cycle all outputs 0, no m_ack, master 0 wins the next arbitration.
- Input change after grant: alter m_addr[0] during ACCESS -> bus_addr unchanged; ack carries data for the original address.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and sizing helpers for the memory bus arbiter.
// Imported by the interface, the winner-select logic and the top.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

    // Always at least one bit, so single-value counters and indices stay legal.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/ack channels of all masters plus the shared memory_bus strobes.
// The slave modport is the arbiter; the master modport is the requesters and the memory.
interface mem_bus_arbiter_if #(
    parameter int WIDTH       = 32,
    parameter int NUM_MASTERS = 2
);
    localparam int BYTES = mem_bus_pkg::bytes_of(WIDTH);

    logic [NUM_MASTERS-1:0]       m_req;
    logic [NUM_MASTERS-1:0]       m_we;
    logic [NUM_MASTERS*WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS*BYTES-1:0] m_byteen;
    logic [NUM_MASTERS-1:0]       m_ack;
    logic [WIDTH-1:0]             m_rdata;

    logic                         bus_mem_read;
    logic                         bus_mem_write;
    logic [WIDTH-1:0]             bus_addr;
    logic [WIDTH-1:0]             bus_wdata;
    logic [BYTES-1:0]             bus_byteen;
    logic [WIDTH-1:0]             bus_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_byteen, bus_rdata,
        output m_ack, m_rdata, bus_mem_read, bus_mem_write, bus_addr, bus_wdata, bus_byteen
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_byteen, bus_rdata,
        input  m_ack, m_rdata, bus_mem_read, bus_mem_write, bus_addr, bus_wdata, bus_byteen
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational winner select: round-robin from last_grant+1 by default,
// plain lowest-index priority encoder when ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifndef ARB_FIXED_PRIORITY_EN
    input  logic [IDX_W-1:0]       last_grant,
`endif
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   valid
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan candidates in priority order; the first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((int'(last_grant) + 1 + k) % NUM_MASTERS);
`endif
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant_idx       = cand;
                grant[cand]     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master memory bus arbiter: one transaction at a time, strobe then one-cycle ack.
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NUM_MASTERS  = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus,
    output logic             busy
);

    localparam int BYTES = bytes_of(WIDTH);
    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int CNT_W = idx_width(READ_LATENCY);

    arb_state_t             state;
    arb_state_t             next_state;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_MASTERS-1:0] grant_q;
    logic                   we_q;
    logic                   first_q;
    logic [WIDTH-1:0]       addr_q;
    logic [WIDTH-1:0]       wdata_q;
    logic [BYTES-1:0]       byteen_q;
    logic [WIDTH-1:0]       rdata_q;

    logic [NUM_MASTERS-1:0] win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;
    logic                   take;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]       last_grant;
`endif

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_arbiter (
        .req        (bus.m_req),
`ifndef ARB_FIXED_PRIORITY_EN
        .last_grant (last_grant),
`endif
        .grant      (win_onehot),
        .grant_idx  (win_idx),
        .valid      (win_valid)
    );

    assign take = (state == IDLE) && win_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid) next_state = ACCESS;
            ACCESS:  if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant-time snapshot of the winner's request; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            grant_q  <= '0;
            we_q     <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            rdata_q  <= '0;
        end else if (take) begin
            cnt      <= CNT_W'(READ_LATENCY - 1);
            grant_q  <= win_onehot;
            we_q     <= bus.m_we[win_idx];
            first_q  <= 1'b1;
            addr_q   <= bus.m_addr[win_idx*WIDTH +: WIDTH];
            wdata_q  <= bus.m_wdata[win_idx*WIDTH +: WIDTH];
            byteen_q <= bus.m_byteen[win_idx*BYTES +: BYTES];
            rdata_q  <= '0;
        end else if (state == ACCESS) begin
            first_q <= 1'b0;
            if (cnt == '0) begin
                if (!we_q) rdata_q <= bus.bus_rdata;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifndef ARB_FIXED_PRIORITY_EN
    // Reset value makes master 0 the first candidate searched.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_MASTERS - 1);
        end else if (take) begin
            last_grant <= win_idx;
        end
    end
`endif

    always_comb begin
        bus.m_ack         = '0;
        bus.m_rdata       = '0;
        bus.bus_mem_read  = 1'b0;
        bus.bus_mem_write = 1'b0;
        bus.bus_addr      = '0;
        bus.bus_wdata     = '0;
        bus.bus_byteen    = '0;
        busy              = (state != IDLE);
        case (state)
            ACCESS: begin
                bus.bus_addr      = addr_q;
                bus.bus_wdata     = wdata_q;
                bus.bus_byteen    = byteen_q;
                bus.bus_mem_read  = first_q && !we_q;
                bus.bus_mem_write = first_q && we_q;
            end
            RESP: begin
                bus.m_ack   = grant_q;
                bus.m_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: READ_LATENCY=1 instance checked through an ack
// scoreboard, READ_LATENCY=3 instance for held-address, input-change and reset-abort cases.
module tb_mem_bus_arbiter;

    typedef struct {
        int          master;
        logic [31:0] rdata;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic busy1;
    logic busy3;

    int assert_count = 0;
    int fail_count   = 0;
    int lat;

    exp_t        sb[$];
    logic [31:0] mem [0:255];

    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.WIDTH(32), .NUM_MASTERS(2)) ifc1 ();
    mem_bus_arbiter_if #(.WIDTH(32), .NUM_MASTERS(2)) ifc3 ();

    mem_bus_arbiter #(.WIDTH(32), .NUM_MASTERS(2), .READ_LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc1),
        .busy  (busy1)
    );

    mem_bus_arbiter #(.WIDTH(32), .NUM_MASTERS(2), .READ_LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc3),
        .busy  (busy3)
    );

    // Word-addressed memory behind dut1 with byte-lane writes.
    assign ifc1.bus_rdata = mem[ifc1.bus_addr[9:2]];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[64] <= 32'hDEADBEEF;
        end else if (ifc1.bus_mem_write) begin
            for (int b = 0; b < 4; b++)
                if (ifc1.bus_byteen[b]) mem[ifc1.bus_addr[9:2]][b*8 +: 8] <= ifc1.bus_wdata[b*8 +: 8];
        end
    end

    // Read-only address-derived memory behind dut3.
    assign ifc3.bus_rdata = ifc3.bus_addr ^ 32'h5A5A_0000;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        ifc1.m_req = '0; ifc1.m_we = '0; ifc1.m_addr = '0; ifc1.m_wdata = '0; ifc1.m_byteen = '0;
        ifc3.m_req = '0; ifc3.m_we = '0; ifc3.m_addr = '0; ifc3.m_wdata = '0; ifc3.m_byteen = '0;
    endtask

    task automatic applyStimulus(input int master, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] byteen);
        ifc1.m_we[master]             = we;
        ifc1.m_addr[master*32 +: 32]  = addr;
        ifc1.m_wdata[master*32 +: 32] = wdata;
        ifc1.m_byteen[master*4 +: 4]  = byteen;
        ifc1.m_req[master]            = 1'b1;
    endtask

    task automatic expectAck(input int master, input logic [31:0] rdata);
        exp_t e;
        e.master = master;
        e.rdata  = rdata;
        sb.push_back(e);
    endtask

    task automatic waitAck(input string tag, input int which, output int cycles);
        cycles = 0;
        while (((which == 1) ? ifc1.m_ack : ifc3.m_ack) == 2'b00 && cycles < 10) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_seen"}, 64'(((which == 1) ? ifc1.m_ack : ifc3.m_ack) != 2'b00), 64'd1);
    endtask

    // Scoreboard pop on every dut1 ack, plus ack/strobe exclusion on both instances.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            checkOutput("excl1", 64'((|ifc1.m_ack) && (ifc1.bus_mem_read || ifc1.bus_mem_write)), 64'd0);
            checkOutput("excl3", 64'((|ifc3.m_ack) && (ifc3.bus_mem_read || ifc3.bus_mem_write)), 64'd0);
            if (ifc1.m_ack != 2'b00) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_ack", 64'(ifc1.m_ack), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_ack_master", 64'(ifc1.m_ack), 64'(2'b01 << e.master));
                    checkOutput("sb_ack_rdata", 64'(ifc1.m_rdata), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        checkOutput("rst_busy1", 64'(busy1), 64'd0);
        checkOutput("rst_ack1", 64'(ifc1.m_ack), 64'd0);
        checkOutput("rst_read1", 64'(ifc1.bus_mem_read), 64'd0);
        checkOutput("rst_write1", 64'(ifc1.bus_mem_write), 64'd0);
        checkOutput("rst_addr1", 64'(ifc1.bus_addr), 64'd0);
        checkOutput("rst_rdata1", 64'(ifc1.m_rdata), 64'd0);
        checkOutput("rst_busy3", 64'(busy3), 64'd0);
        reset = 1'b0;

        // Single read by master 0
        expectAck(0, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'hF);
        tick();
        checkOutput("rd_strobe", 64'(ifc1.bus_mem_read), 64'd1);
        checkOutput("rd_nowrite", 64'(ifc1.bus_mem_write), 64'd0);
        checkOutput("rd_addr", 64'(ifc1.bus_addr), 64'h100);
        checkOutput("rd_busy", 64'(busy1), 64'd1);
        tick();
        checkOutput("rd_ack", 64'(ifc1.m_ack), 64'b01);
        checkOutput("rd_rdata", 64'(ifc1.m_rdata), 64'hDEADBEEF);
        checkOutput("rd_strobe_off", 64'(ifc1.bus_mem_read), 64'd0);
        ifc1.m_req = '0;
        tick();
        checkOutput("rd_idle", 64'(busy1), 64'd0);

        // Partial write by master 1, then read back
        expectAck(1, 32'h0);
        applyStimulus(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b0011);
        tick();
        checkOutput("wr_strobe", 64'(ifc1.bus_mem_write), 64'd1);
        checkOutput("wr_noread", 64'(ifc1.bus_mem_read), 64'd0);
        checkOutput("wr_addr", 64'(ifc1.bus_addr), 64'h40);
        checkOutput("wr_wdata", 64'(ifc1.bus_wdata), 64'hCAFEF00D);
        checkOutput("wr_byteen", 64'(ifc1.bus_byteen), 64'b0011);
        tick();
        checkOutput("wr_ack", 64'(ifc1.m_ack), 64'b10);
        checkOutput("wr_strobe_off", 64'(ifc1.bus_mem_write), 64'd0);
        ifc1.m_req = '0;
        tick();
        expectAck(0, 32'h0000F00D);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'hF);
        waitAck("rb", 1, lat);
        checkOutput("rb_latency", 64'(lat), 64'd2);
        checkOutput("rb_rdata", 64'(ifc1.m_rdata), 64'h0000F00D);
        ifc1.m_req = '0;
        tick();

        // Contention from a fresh reset, both masters holding requests
        reset = 1'b1;
        clearInputs();
        tick();
        reset = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) expectAck(0, 32'hDEADBEEF);
`else
        for (int i = 0; i < 4; i++) expectAck(i % 2, (i % 2 == 0) ? 32'hDEADBEEF : 32'h0);
`endif
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'hF);
        applyStimulus(1, 1'b0, 32'h44, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            waitAck("cont", 1, lat);
            checkOutput("cont_latency", 64'(lat), 64'd2);
`ifdef ARB_FIXED_PRIORITY_EN
            checkOutput("cont_grant", 64'(ifc1.m_ack), 64'b01);
`else
            checkOutput("cont_grant", 64'(ifc1.m_ack), 64'(2'b01 << (i % 2)));
`endif
        end
        ifc1.m_req = '0;
        tick();
        tick();
        checkOutput("cont_idle", 64'(busy1), 64'd0);

        // READ_LATENCY=3: address held, single strobe, input change ignored
        ifc3.m_addr[31:0] = 32'h200;
        ifc3.m_req[0]     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checkOutput("rl3_addr", 64'(ifc3.bus_addr), 64'h200);
            checkOutput("rl3_strobe", 64'(ifc3.bus_mem_read), 64'(c == 1));
            checkOutput("rl3_busy", 64'(busy3), 64'd1);
            checkOutput("rl3_noack", 64'(ifc3.m_ack), 64'd0);
            if (c == 2) ifc3.m_addr[31:0] = 32'h300;
        end
        tick();
        checkOutput("rl3_ack", 64'(ifc3.m_ack), 64'b01);
        checkOutput("rl3_rdata", 64'(ifc3.m_rdata), 64'h5A5A0200);
        checkOutput("rl3_resp_busy", 64'(busy3), 64'd1);
        ifc3.m_req = '0;
        tick();
        checkOutput("rl3_idle", 64'(busy3), 64'd0);

        // Reset during the second ACCESS cycle aborts and restores master 0 priority
        ifc3.m_addr[31:0]  = 32'h200;
        ifc3.m_addr[63:32] = 32'h280;
        ifc3.m_req         = 2'b01;
        tick();
        tick();
        reset      = 1'b1;
        ifc3.m_req = 2'b11;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy3), 64'd0);
        checkOutput("abort_ack", 64'(ifc3.m_ack), 64'd0);
        checkOutput("abort_read", 64'(ifc3.bus_mem_read), 64'd0);
        checkOutput("abort_addr", 64'(ifc3.bus_addr), 64'd0);
        checkOutput("abort_rdata", 64'(ifc3.m_rdata), 64'd0);
        tick();
        checkOutput("abort_winner_addr", 64'(ifc3.bus_addr), 64'h200);
        checkOutput("abort_winner_strobe", 64'(ifc3.bus_mem_read), 64'd1);
        waitAck("abort_ack_after", 3, lat);
        checkOutput("abort_ack_master", 64'(ifc3.m_ack), 64'b01);
        checkOutput("abort_ack_rdata", 64'(ifc3.m_rdata), 64'h5A5A0200);
        ifc3.m_req = '0;
        tick();

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
